ifu_axi_fetch: RTL

- Multi-cycle instruction fetch unit; replaces the combinational instruction-memory read between the PC register and the decode stage.
- Issues one AXI4-Lite read per instruction to instruction memory, holds the returned word, and presents it to decode over a valid/ready handshake.
- Accepts the next PC from execute and reports misaligned, bus-error and timeout faults alongside the instruction.

---
 rtl/ifu_axi_fetch_pkg.sv | 24 ++
 rtl/ifu_axi_fetch_if.sv | 15 +
 rtl/ifu_axi_fetch_chk.sv | 14 +
 rtl/ifu_timeout_ctr.sv | 28 ++
 rtl/ifu_axi_fetch.sv | 133 +++++++++++++
 5 files changed

// File: rtl/ifu_axi_fetch_pkg.sv
// Core-wide definitions shared by the instruction fetch unit.
// Covers the fetch FSM states, fault codes and the AXI response encoding.
package ifu_axi_fetch_pkg;

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_IDLE = 3'd4
    } fetch_state_e;

    localparam logic [1:0]  FLT_NONE  = 2'b00;
    localparam logic [1:0]  FLT_MIS   = 2'b01;
    localparam logic [1:0]  FLT_BUS   = 2'b10;
    localparam logic [1:0]  FLT_TMO   = 2'b11;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_axi_fetch_if.sv
// AXI4-Lite read channels between the fetch unit (master) and instruction memory (slave).
interface ifu_axi_fetch_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (output araddr, arvalid, rready,
                    input  arready, rdata, rresp, rvalid);
    modport slave  (input  araddr, arvalid, rready,
                    output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/ifu_axi_fetch_chk.sv
// Protocol checker: execute may only present next_pc when the fetch unit can consume it.
module ifu_axi_fetch_chk
    import ifu_axi_fetch_pkg::*;
(
    input logic         clk,
    input logic         rst,
    input fetch_state_e state,
    input logic         next_pc_valid,
    input logic         inst_ready
);
    // next_pc is consumed only in S_IDLE or together with an S_OUT handshake
    npc_legal: assert property (@(posedge clk) disable iff (rst)
        next_pc_valid |-> ((state == S_IDLE) || ((state == S_OUT) && inst_ready)));
endmodule

// File: rtl/ifu_timeout_ctr.sv
// Clearable saturating cycle counter; hit is high once TIMEOUT cycles have been counted.
module ifu_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int            W     = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_r;

    // count enabled cycles, holding at LIMIT so hit stays asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    assign hit = (cnt_r == LIMIT);
endmodule

// File: rtl/ifu_axi_fetch.sv
// Multi-cycle instruction fetch: one AXI4-Lite read per instruction, delivered to decode
// over valid/ready with a fault code (misaligned, bus error, timeout).
module ifu_axi_fetch
    import ifu_axi_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       next_pc,
    input  logic              next_pc_valid,
    ifu_axi_fetch_if.master   axi,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [1:0]        fault,
    output logic [CNT_W-1:0]  fetch_cnt
);
    fetch_state_e     state_r, state_s;
    logic [31:0]      pc_r, pc_s, inst_s, inst_pc_s;
    logic [1:0]       fault_s;
    logic [CNT_W-1:0] fetch_cnt_s;
    logic             tmo_clr_s, tmo_en_s, tmo_hit_s, take_pc_s;

    ifu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr_s),
        .en  (tmo_en_s),
        .hit (tmo_hit_s)
    );

    ifu_axi_fetch_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .state         (state_r),
        .next_pc_valid (next_pc_valid),
        .inst_ready    (inst_ready)
    );

    // handshake outputs are pure state decodes, keeping inputs off every output path
    assign axi.araddr  = pc_r;
    assign axi.arvalid = (state_r == S_REQ);
    assign axi.rready  = (state_r == S_WAIT);
    assign inst_valid  = (state_r == S_OUT);

    // next-state and datapath load decisions
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        inst_s      = inst;
        inst_pc_s   = inst_pc;
        fault_s     = fault;
        fetch_cnt_s = fetch_cnt;
        tmo_clr_s   = 1'b0;
        tmo_en_s    = 1'b0;
        take_pc_s   = 1'b0;
        case (state_r)
            S_BOOT: state_s = S_REQ;
            S_REQ: begin
                if (axi.arready) begin
                    state_s   = S_WAIT;
                    tmo_clr_s = 1'b1;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                tmo_en_s = 1'b1;
                if (axi.rvalid) begin
                    inst_s    = axi.rdata;
                    inst_pc_s = pc_r;
                    fault_s   = (axi.rresp == RESP_OKAY) ? FLT_NONE : FLT_BUS;
                    state_s   = S_OUT;
                end else if (tmo_hit_s) begin
                    inst_s    = NOP_INST;
                    inst_pc_s = pc_r;
                    fault_s   = FLT_TMO;
                    state_s   = S_OUT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    fetch_cnt_s = fetch_cnt + CNT_W'(1);
                    state_s     = S_IDLE;
                    take_pc_s   = next_pc_valid;
                end else begin
                    state_s = S_OUT;
                end
            end
            S_IDLE:  take_pc_s = next_pc_valid;
            default: state_s = S_BOOT;
        endcase
        // a misaligned target never reaches the bus; it is reported straight away
        if (take_pc_s) begin
            pc_s = next_pc;
            if (is_aligned(next_pc)) begin
                state_s = S_REQ;
            end else begin
                inst_s    = NOP_INST;
                inst_pc_s = next_pc;
                fault_s   = FLT_MIS;
                state_s   = S_OUT;
            end
        end else begin
            pc_s = pc_r;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_BOOT;
            pc_r      <= RESET_PC;
            inst      <= 32'h0000_0000;
            inst_pc   <= RESET_PC;
            fault     <= FLT_NONE;
            fetch_cnt <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            inst      <= inst_s;
            inst_pc   <= inst_pc_s;
            fault     <= fault_s;
            fetch_cnt <= fetch_cnt_s;
        end
    end
endmodule
